// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity framer: FSM encoding, default
// frame length and the bit-counter width helper.
package parity_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_BITS = 8;

    // Wide enough to hold the value DATA_BITS itself, not just DATA_BITS-1.
    function automatic int cnt_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/parity_acc.sv
// Single-bit XOR accumulator: load seeds the flop, enable folds in one bit.
// acc_next exposes the feedback XOR so the parent can capture the final parity.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic seed,
    input  logic en,
    input  logic din,
    output logic acc,
    output logic acc_next
);

    xorgate u_xor (
        .a (acc),
        .b (din),
        .y (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= 1'b0;
        else if (load)
            acc <= seed;
        else if (en)
            acc <= acc_next;
    end

endmodule

// File: rtl/xorgate.sv
// Two-input XOR gate stage used for the parity feedback path.
module xorgate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/serial_parity_framer.sv
// Frames DATA_BITS serial bits and produces their parity with a one-cycle done.
// Define SERIAL_PARITY_CHECK_EN to add a received-parity CHECK state and par_err.
module serial_parity_framer
    import parity_pkg::*;
#(
    parameter int   DATA_BITS = DEFAULT_DATA_BITS,
    parameter logic ODD       = 1'b0,
    parameter int   CW        = cnt_width(DATA_BITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          din,
    input  logic          din_valid,
    output logic          busy,
    output logic [CW-1:0] bit_cnt,
    output logic          par_acc,
    output logic          par_out,
    output logic          done,
    output logic          par_err
);

    state_t state;
    logic   acc_load;
    logic   acc_en;
    logic   acc_next;
    logic   last_bit;

    assign acc_load = start && (state == S_IDLE || state == S_DONE);
    assign acc_en   = din_valid && (state == S_SHIFT);
    assign last_bit = (bit_cnt == CW'(DATA_BITS - 1));

    parity_acc u_acc (
        .clk      (clk),
        .rst      (rst),
        .load     (acc_load),
        .seed     (ODD),
        .en       (acc_en),
        .din      (din),
        .acc      (par_acc),
        .acc_next (acc_next)
    );

`ifdef SERIAL_PARITY_CHECK_EN
    logic par_err_r;
    assign par_err = par_err_r;
`else
    assign par_err = 1'b0;
`endif

    // busy and done are set together with the state transition so they are pure flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            par_out <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
`ifdef SERIAL_PARITY_CHECK_EN
                        par_err_r <= 1'b0;
`endif
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (din_valid) begin
                        bit_cnt <= bit_cnt + CW'(1);
                        if (last_bit) begin
                            par_out <= acc_next;
`ifdef SERIAL_PARITY_CHECK_EN
                            state <= S_CHECK;
`else
                            state <= S_DONE;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef SERIAL_PARITY_CHECK_EN
                S_CHECK: begin
                    if (din_valid) begin
                        par_err_r <= din ^ par_out;
                        state     <= S_DONE;
                        done      <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parity_framer.sv
// Scoreboard bench: even (ODD=0) and odd (ODD=1) framers share one stimulus stream;
// expected parity results are queued per frame and popped on every done pulse.
module tb_serial_parity_framer;

    typedef struct {
        logic par;
        logic err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;

    logic       busy0, busy1;
    logic [3:0] cnt0, cnt1;
    logic       acc0, acc1;
    logic       pout0, pout1;
    logic       done0, done1;
    logic       err0, err1;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_parity_framer #(.DATA_BITS(8), .ODD(1'b0)) dut_even (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .busy(busy0), .bit_cnt(cnt0), .par_acc(acc0), .par_out(pout0),
        .done(done0), .par_err(err0)
    );

    serial_parity_framer #(.DATA_BITS(8), .ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .busy(busy1), .bit_cnt(cnt1), .par_acc(acc1), .par_out(pout1),
        .done(done1), .par_err(err1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Each done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                checkOutput("even unexpected done", 32'(done0), 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                checkOutput("even par_out", 32'(pout0), 32'(e.par));
                checkOutput("even par_err", 32'(err0), 32'(e.err));
                checkOutput("even bit_cnt at done", 32'(cnt0), 32'd8);
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                checkOutput("odd unexpected done", 32'(done1), 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                checkOutput("odd par_out", 32'(pout1), 32'(e.par));
                checkOutput("odd par_err", 32'(err1), 32'(e.err));
            end
        end
    end

    // bits[7] is sent first; pbit is the received parity bit when checking is compiled in.
    task automatic applyStimulus(input logic [7:0] bits, input bit gap, input bit cnt_check,
                                 input bit do_start, input bit chain, input logic pbit);
        exp_t e0, e1;
        e0.par = ^bits;
        e1.par = ~(^bits);
`ifdef SERIAL_PARITY_CHECK_EN
        e0.err = pbit ^ e0.par;
        e1.err = pbit ^ e1.par;
`else
        e0.err = 1'b0;
        e1.err = 1'b0;
`endif
        q0.push_back(e0);
        q1.push_back(e1);
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            din       = bits[7-i];
            din_valid = 1'b1;
`ifndef SERIAL_PARITY_CHECK_EN
            if (chain && i == 7)
                start = 1'b1;
`endif
            step();
            din_valid = 1'b0;
            if (cnt_check) begin
                @(negedge clk);
                checkOutput("gapped bit_cnt", 32'(cnt0), 32'(i + 1));
            end
            if (gap && i < 7) begin
                if (i == 2)
                    start = 1'b1;
                step();
                start = 1'b0;
            end
        end
`ifdef SERIAL_PARITY_CHECK_EN
        din       = pbit;
        din_valid = 1'b1;
        if (chain)
            start = 1'b1;
        step();
        din_valid = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held for two cycles, then data pulses with no start must be ignored.
        step();
        step();
        @(negedge clk);
        checkOutput("reset busy", 32'(busy0), 32'd0);
        checkOutput("reset bit_cnt", 32'(cnt0), 32'd0);
        checkOutput("reset par_acc odd", 32'(acc1), 32'd0);
        checkOutput("reset par_out odd", 32'(pout1), 32'd0);
        checkOutput("reset done", 32'(done0), 32'd0);
        checkOutput("reset par_err", 32'(err0), 32'd0);
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            din       = 1'b1;
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle bit_cnt", 32'(cnt0), 32'd0);
        checkOutput("idle busy", 32'(busy1), 32'd0);
        checkOutput("idle par_acc", 32'(acc1), 32'd0);
        checkOutput("idle par_out", 32'(pout0), 32'd0);

        // Even/odd frame 1,0,1,1,0,0,1,0 (four ones).
        applyStimulus(8'b1011_0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        @(negedge clk);
        checkOutput("idle after frame busy", 32'(busy0), 32'd0);
        checkOutput("held bit_cnt", 32'(cnt0), 32'd8);
        checkOutput("held par_acc odd", 32'(acc1), 32'd1);

        // Gapped frame 1,1,1,0,0,0,0,0 with a stray start after bit 3.
        applyStimulus(8'b1110_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        step();

        // Back-to-back: start held through DONE, second frame has no IDLE cycle.
        applyStimulus(8'b0000_0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        start = 1'b0;
        @(negedge clk);
        checkOutput("chain busy", 32'(busy0), 32'd1);
        checkOutput("chain bit_cnt", 32'(cnt0), 32'd0);
        checkOutput("chain par_acc odd", 32'(acc1), 32'd1);
        applyStimulus(8'b0101_0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // Reset three bits into a frame: everything clears without a clock edge.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din       = 1'b1;
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async rst busy", 32'(busy0), 32'd0);
        checkOutput("async rst bit_cnt", 32'(cnt0), 32'd0);
        checkOutput("async rst par_acc", 32'(acc0), 32'd0);
        checkOutput("async rst par_out odd", 32'(pout1), 32'd0);
        checkOutput("async rst done", 32'(done0), 32'd0);
        step();
        rst = 1'b0;
        step();
        applyStimulus(8'b1111_1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();

        // Received-parity frames: mismatch then match for the even framer.
        applyStimulus(8'b1000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(8'b1000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        step();
        @(negedge clk);
        checkOutput("par_err held", 32'(err0), 32'd0);
        checkOutput("even queue drained", 32'(q0.size()), 32'd0);
        checkOutput("odd queue drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_framer.md
Name: serial_parity_framer

Overview:
- Bit-serial parity generator that frames DATA_BITS serial data bits and XOR-accumulates them into a single parity bit.
- Sits directly upstream of the 2-input XOR gate stage: it supplies framed bit streams and consumes XOR results.
- A one-cycle `done` pulse tells downstream logic that `par_out` is valid.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 1..255.
- ODD, 0, parity sense: 0 = even parity, 1 = odd parity (`par_out` = XOR of data bits ^ ODD).
- CW, $clog2(DATA_BITS+1), width of `bit_cnt`; derived, not for override.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a new frame; sampled in IDLE and DONE only.
- din  in  1  serial data bit.
- din_valid  in  1  `din` qualifier; a bit is accepted on a rising edge with `din_valid`=1 in SHIFT or CHECK.
- busy  out  1  high when state != IDLE.
- bit_cnt  out  CW  data bits accepted in the current frame.
- par_acc  out  1  running parity (includes ODD seed).
- par_out  out  1  final frame parity; held until the next `start` is accepted.
- done  out  1  one-cycle pulse marking frame completion.
- par_err  out  1  received-parity mismatch; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, bit_cnt=0, par_acc=0, par_out=0, done=0, par_err=0. A partial frame is discarded.
- States: IDLE, SHIFT, DONE, and CHECK (CHECK exists only with the feature). Encoding is 2 bits.
- IDLE:
  - start=1 -> SHIFT; par_acc<=ODD, bit_cnt<=0, par_err<=0.
  - din/din_valid are ignored.
- SHIFT:
  - Each edge with din_valid=1: par_acc<=par_acc^din, bit_cnt<=bit_cnt+1.
  - din_valid=0: hold all state; gaps of any length are allowed.
  - Accepting bit DATA_BITS (bit_cnt==DATA_BITS-1): par_out<=par_acc^din on that same edge; next state DONE, or CHECK with the feature.
  - start is ignored while in SHIFT.
- DONE:
  - Lasts exactly one cycle; done = (state==DONE), registered state decode, no combinational path from inputs.
  - start=1 in DONE -> SHIFT with the same initialisation as in IDLE (back-to-back frames, zero bubble).
  - Otherwise -> IDLE.
- Latency: last data bit accepted at edge k -> par_out valid after edge k; done high for the cycle between edges k and k+1.
- DATA_BITS=1: the first accepted bit completes the frame.
- bit_cnt and par_acc hold their final values in DONE/IDLE until the next start. The counter never wraps, because the frame ends at DATA_BITS.
- rst asserted together with start or din_valid: reset wins.

Optional Feature:
- Macro: SERIAL_PARITY_CHECK_EN.
- Defined:
  - After the last data bit the FSM enters CHECK and waits for the next din_valid=1.
  - That din is the received parity bit: par_err<=din^par_out, then -> DONE.
  - bit_cnt does not count the parity bit.
  - par_err holds until the next accepted start or reset.
- Undefined:
  - CHECK state logic is not compiled; SHIFT goes directly to DONE.
  - par_err is tied to 0.

Decomposition:
- Shared package `parity_pkg`:
  - state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2, S_CHECK=2'd3;
  - default DATA_BITS constant;
  - counter-width function.
- One sub-module, `parity_acc`: single-bit XOR accumulator flop with load (seed ODD), enable, async reset. It instantiates the existing xorgate for the feedback XOR.
- FSM and counter stay in the top module.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then din_valid=1 pulses with no start -> all outputs 0, bit_cnt stays 0.
- Even frame: DATA_BITS=8, ODD=0, start then bits 1,0,1,1,0,0,1,0 on consecutive cycles -> par_out=0, done high 1 cycle after the 8th bit, bit_cnt=8. Same bits with ODD=1 -> par_out=1.
- Gapped input and ignored start: bits 1,1,1,0,0,0,0,0 with din_valid low every other cycle, plus start=1 pulsed after bit 3 -> bit_cnt counts 0..8 unbroken, par_out=1, exactly one done pulse.
- Back-to-back and mid-frame reset:
  - start held high through DONE -> second frame begins with no IDLE cycle.
  - rst asserted after 3 bits of a frame -> all outputs 0 immediately; a following all-ones frame gives par_out=0.
- Feature (SERIAL_PARITY_CHECK_EN):
  - bits 1,0,0,0,0,0,0,0 then parity bit 0 -> par_err=1, done after the parity bit.
  - Repeat with parity bit 1 -> par_err=0.
  - Without the macro -> par_err=0 always.
